// File: rtl/masked_hpc3_mul_pipe.sv
// Masked GF(2^BIT_WIDTH) multiplier (HPC3 style) with valid/ready flow control
// on operands and randomness, optional output register stage and a counter
// of completed hand-offs.
//
// Handshake semantics (all three interfaces):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   A producer holding valid must keep its data stable until the transfer.
//   Operands and randomness are consumed together: fire_in requires in_valid,
//   in_rand_valid and in_ready. in_rand_ready is exactly fire_in. in_ready
//   never depends on in_valid or in_rand_valid. out_valid/out_c stay stable
//   while out_ready is low.
module masked_hpc3_mul_pipe #(
  parameter int NUM_SHARES  = 2,
  parameter int BIT_WIDTH   = 4,
  parameter int OUT_REG     = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                                in_clock,
  input  logic                                                in_reset,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]                     in_a,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]                     in_b,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0]  in_r,
  input  logic [(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0]  in_p,
  input  logic                                                in_rand_valid,
  output logic                                                in_rand_ready,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]                     out_c,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [COUNT_WIDTH-1:0]                              out_count
);

  localparam int N  = NUM_SHARES;
  localparam int W  = BIT_WIDTH;
  localparam int NQ = N * (N - 1) / 2;

  // Reduction polynomial of the field, x^W term included.
  function automatic int field_poly(input int w);
    case (w)
      2:       return 'h7;
      3:       return 'hB;
      4:       return 'h13;
      5:       return 'h25;
      6:       return 'h43;
      7:       return 'h83;
      8:       return 'h11B;
      default: return (1 << w) | 3;
    endcase
  endfunction

  localparam logic [W:0] POLY = (W+1)'(field_poly(W));

  typedef logic [W-1:0] elem_t;

  // Field multiplication: shift-and-add with reduction on each doubling.
  function automatic elem_t gf_mul(input elem_t x, input elem_t y);
    elem_t acc;
    elem_t sh;
    acc = '0;
    sh  = x;
    for (int k = 0; k < W; k++) begin
      if (y[k]) acc ^= sh;
      sh = sh[W-1] ? ((sh << 1) ^ POLY[W-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // Index of the unordered share pair {i,j}, i != j.
  function automatic int qindex(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * N - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  elem_t a_sh [N];
  elem_t b_sh [N];
  elem_t r_q  [NQ];
  elem_t p_q  [NQ];

  for (genvar g = 0; g < N; g++) begin : g_unpack_ab
    assign a_sh[g] = in_a[g*W +: W];
    assign b_sh[g] = in_b[g*W +: W];
  end

  for (genvar g = 0; g < NQ; g++) begin : g_unpack_rp
    assign r_q[g] = in_r[g*W +: W];
    assign p_q[g] = in_p[g*W +: W];
  end

  logic fire_in;
  logic s1_take;
  logic s1_v;

  assign fire_in       = in_valid & in_rand_valid & in_ready;
  assign in_rand_ready = fire_in;

  // Cross-share terms computed ahead of the stage-1 register; the diagonal
  // stays zero.
  elem_t v_d [N][N];
  elem_t w_d [N][N];

  // Build V_ij = b_j ^ r_q and W_ij = a_i*r_q ^ p_q for all i != j.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        v_d[i][j] = '0;
        w_d[i][j] = '0;
        if (i != j) begin
          v_d[i][j] = b_sh[j] ^ r_q[qindex(i, j)];
          w_d[i][j] = gf_mul(a_sh[i], r_q[qindex(i, j)]) ^ p_q[qindex(i, j)];
        end
      end
    end
  end

  elem_t s1_a  [N];
  elem_t s1_b  [N];
  elem_t s1_vv [N][N];
  elem_t s1_w  [N][N];

  // Stage-1 data loads only on an accepted operand and otherwise holds.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int i = 0; i < N; i++) begin
        s1_a[i] <= '0;
        s1_b[i] <= '0;
        for (int j = 0; j < N; j++) begin
          s1_vv[i][j] <= '0;
          s1_w[i][j]  <= '0;
        end
      end
    end else if (fire_in) begin
      for (int i = 0; i < N; i++) begin
        s1_a[i] <= a_sh[i];
        s1_b[i] <= b_sh[i];
        for (int j = 0; j < N; j++) begin
          s1_vv[i][j] <= v_d[i][j];
          s1_w[i][j]  <= w_d[i][j];
        end
      end
    end
  end

  // Stage-1 occupancy: set on accept, cleared when handed downstream.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset)    s1_v <= 1'b0;
    else if (fire_in) s1_v <= 1'b1;
    else if (s1_take) s1_v <= 1'b0;
  end

  elem_t b_red [N];
  elem_t w_red [N];
  logic [N*W-1:0] c_flat;

  // Post-register reduction: c_i = a_i*(b_i ^ XOR_j V_ij) ^ XOR_j W_ij.
  always_comb begin
    c_flat = '0;
    for (int i = 0; i < N; i++) begin
      b_red[i] = s1_b[i];
      w_red[i] = '0;
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          b_red[i] ^= s1_vv[i][j];
          w_red[i] ^= s1_w[i][j];
        end
      end
      c_flat[i*W +: W] = gf_mul(s1_a[i], b_red[i]) ^ w_red[i];
    end
  end

  if (OUT_REG == 0) begin : g_direct
    assign out_c     = c_flat;
    assign out_valid = s1_v;
    assign s1_take   = s1_v & out_ready;
    assign in_ready  = !s1_v | out_ready;
  end else begin : g_reg
    logic [N*W-1:0] s2_c;
    logic           s2_v;

    assign s1_take = s1_v & (!s2_v | out_ready);

    // Output stage: captures stage 1 when it is free or being drained.
    always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
        s2_c <= '0;
        s2_v <= 1'b0;
      end else begin
        if (s1_take)        s2_c <= c_flat;
        if (s1_take)        s2_v <= 1'b1;
        else if (out_ready) s2_v <= 1'b0;
      end
    end

    assign out_c     = s2_c;
    assign out_valid = s2_v;
    assign in_ready  = !s1_v | !s2_v | out_ready;
  end

  // Completed hand-offs; wraps silently.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset)                  out_count <= '0;
    else if (out_valid & out_ready) out_count <= out_count + 1'b1;
  end

endmodule

// File: tb/tb_masked_hpc3_mul_pipe.sv
// Bench for masked_hpc3_mul_pipe: u0 = 2 shares, combinational output;
// u1 = 3 shares, registered output, 4-bit counter.
module tb_masked_hpc3_mul_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- u0 signals ----------------
  logic [7:0]  a0, b0, c0;
  logic [3:0]  r0, p0;
  logic        valid0, ready0, rv0, rr0, ov0, or0;
  logic [15:0] cnt0;

  // ---------------- u1 signals ----------------
  logic [11:0] a1, b1, r1, p1, c1;
  logic        valid1, ready1, rv1, rr1, ov1, or1;
  logic [3:0]  cnt1;

  masked_hpc3_mul_pipe #(.NUM_SHARES(2), .BIT_WIDTH(4), .OUT_REG(0), .COUNT_WIDTH(16)) u0 (
    .in_clock(clk), .in_reset(rst_n), .in_a(a0), .in_b(b0), .in_valid(valid0),
    .in_ready(ready0), .in_r(r0), .in_p(p0), .in_rand_valid(rv0), .in_rand_ready(rr0),
    .out_c(c0), .out_valid(ov0), .out_ready(or0), .out_count(cnt0));

  masked_hpc3_mul_pipe #(.NUM_SHARES(3), .BIT_WIDTH(4), .OUT_REG(1), .COUNT_WIDTH(4)) u1 (
    .in_clock(clk), .in_reset(rst_n), .in_a(a1), .in_b(b1), .in_valid(valid1),
    .in_ready(ready1), .in_r(r1), .in_p(p1), .in_rand_valid(rv1), .in_rand_ready(rr1),
    .out_c(c1), .out_valid(ov1), .out_ready(or1), .out_count(cnt1));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0]  exp0_q[$];
  logic [3:0]  exp1_q[$];
  logic [3:0]  cur_a0, cur_b0, cur_a1, cur_b1;
  logic [15:0] mcnt0 = '0;
  logic [3:0]  mcnt1 = '0;
  int          acc1 = 0;
  int          rr0_pulses = 0;
  logic        hold0_prev = 1'b0, hold1_prev = 1'b0;
  logic [7:0]  c0_prev;
  logic [11:0] c1_prev;

  // GF(2^4), x^4+x+1: carry-less product then fold the high bits.
  function automatic logic [3:0] model_mul(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] prod;
    prod = '0;
    for (int k = 0; k < 4; k++) if (y[k]) prod ^= 7'(x) << k;
    for (int k = 6; k >= 4; k--) if (prod[k]) prod ^= 7'(5'h13) << (k - 4);
    return prod[3:0];
  endfunction

  function automatic logic [3:0] unmask0(input logic [7:0] c);
    return c[3:0] ^ c[7:4];
  endfunction

  function automatic logic [3:0] unmask1(input logic [11:0] c);
    return c[3:0] ^ c[7:4] ^ c[11:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ops0(input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] s;
    cur_a0 = av; cur_b0 = bv;
    s = 4'($urandom); a0 = {av ^ s, s};
    s = 4'($urandom); b0 = {bv ^ s, s};
    r0 = 4'($urandom); p0 = 4'($urandom);
  endtask

  task automatic set_ops1(input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] s, t;
    cur_a1 = av; cur_b1 = bv;
    s = 4'($urandom); t = 4'($urandom); a1 = {av ^ s ^ t, t, s};
    s = 4'($urandom); t = 4'($urandom); b1 = {bv ^ s ^ t, t, s};
    r1 = 12'($urandom); p1 = 12'($urandom);
  endtask

  // mode 0: random operands, 1: a=ONE b=0xB, 2: exhaustive index k -> (a,b)
  task automatic next_op1(input int mode, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    case (mode)
      1:       set_ops1(4'h1, 4'hB);
      2:       set_ops1(kk[7:4], kk[3:0]);
      default: set_ops1(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endcase
  endtask

  // Called at posedge+#1; keeps operands offered until n accepts.
  task automatic feed1(input int n, input int mode, output int cyc);
    int done;
    bit f;
    done = 0; cyc = 0;
    next_op1(mode, 0);
    valid1 = 1'b1; rv1 = 1'b1;
    while (done < n && cyc < 8 * n + 50) begin
      @(negedge clk); f = valid1 & rv1 & ready1;
      @(posedge clk); #1; cyc++;
      if (f) begin
        done++;
        if (done < n) next_op1(mode, done);
      end
    end
    valid1 = 1'b0; rv1 = 1'b0;
    check("feed1_done", 32'(done), 32'(n));
  endtask

  task automatic feed0(input int n);
    int done, cyc;
    bit f;
    done = 0; cyc = 0;
    set_ops0(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    valid0 = 1'b1; rv0 = 1'b1;
    while (done < n && cyc < 8 * n + 50) begin
      @(negedge clk); f = valid0 & rv0 & ready0;
      @(posedge clk); #1; cyc++;
      if (f) begin
        done++;
        set_ops0(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end
    valid0 = 1'b0; rv0 = 1'b0;
    check("feed0_done", 32'(done), 32'(n));
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("rand_ready0", 32'(rr0), 32'(valid0 & rv0 & ready0));
      if (rr0) rr0_pulses++;
      if (valid0 & rv0 & ready0) exp0_q.push_back(model_mul(cur_a0, cur_b0));
      if (hold0_prev) begin
        check("hold_valid0", 32'(ov0), 32'd1);
        check("hold_c0", 32'(c0), 32'(c0_prev));
      end
      if (ov0 && or0) begin
        check("pending0", 32'(exp0_q.size() > 0), 32'd1);
        if (exp0_q.size() > 0) check("unmask0", 32'(unmask0(c0)), 32'(exp0_q.pop_front()));
        check("count0", 32'(cnt0), 32'(mcnt0));
        mcnt0++;
      end
      hold0_prev = ov0 & !or0;
      c0_prev = c0;
    end else begin
      hold0_prev = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("rand_ready1", 32'(rr1), 32'(valid1 & rv1 & ready1));
      if (valid1 & rv1 & ready1) begin
        exp1_q.push_back(model_mul(cur_a1, cur_b1));
        acc1++;
      end
      if (hold1_prev) begin
        check("hold_valid1", 32'(ov1), 32'd1);
        check("hold_c1", 32'(c1), 32'(c1_prev));
      end
      if (ov1 && or1) begin
        check("pending1", 32'(exp1_q.size() > 0), 32'd1);
        if (exp1_q.size() > 0) check("unmask1", 32'(unmask1(c1)), 32'(exp1_q.pop_front()));
        check("count1", 32'(cnt1), 32'(mcnt1));
        mcnt1++;
      end
      hold1_prev = ov1 & !or1;
      c1_prev = c1;
    end else begin
      hold1_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int base;
    bit toggling;
    rst_n = 1'b0;
    a0 = '0; b0 = '0; r0 = '0; p0 = '0; valid0 = 1'b0; rv0 = 1'b0; or0 = 1'b1;
    a1 = '0; b1 = '0; r1 = '0; p1 = '0; valid1 = 1'b0; rv1 = 1'b0; or1 = 1'b1;
    cur_a0 = '0; cur_b0 = '0; cur_a1 = '0; cur_b1 = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ov0", 32'(ov0), 32'd0);
    check("rst_c0", 32'(c0), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_c1", 32'(c1), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready0_after_rst", 32'(ready0), 32'd1);
    check("ready1_after_rst", 32'(ready1), 32'd1);

    // basic: a = 0 (5,5), b = 7 (3,4), one-cycle latency
    @(posedge clk); #1;
    a0 = {4'h5, 4'h5}; b0 = {4'h4, 4'h3}; cur_a0 = 4'h0; cur_b0 = 4'h7;
    r0 = 4'($urandom); p0 = 4'($urandom);
    valid0 = 1'b1; rv0 = 1'b1;
    base = rr0_pulses;
    @(negedge clk);
    @(posedge clk); #1 valid0 = 1'b0; rv0 = 1'b0;
    @(negedge clk);
    check("basic_lat1_valid", 32'(ov0), 32'd1);
    check("basic_zero", 32'(unmask0(c0)), 32'd0);
    repeat (2) @(negedge clk);
    check("basic_rr_once", 32'(rr0_pulses - base), 32'd1);

    // randomness starvation
    @(posedge clk); #1;
    set_ops0(4'h9, 4'h6);
    valid0 = 1'b1; rv0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("starve_rr", 32'(rr0), 32'd0);
      check("starve_ov", 32'(ov0), 32'd0);
      @(posedge clk); #1;
    end
    rv0 = 1'b1;
    @(negedge clk);
    check("unstarve_rr", 32'(rr0), 32'd1);
    @(posedge clk); #1 valid0 = 1'b0; rv0 = 1'b0;
    @(negedge clk);
    check("unstarve_ov", 32'(ov0), 32'd1);

    // u1 two-cycle latency
    @(posedge clk); #1;
    set_ops1(4'h1, 4'hB);
    valid1 = 1'b1; rv1 = 1'b1;
    @(negedge clk);
    check("lat2_fire", 32'(rr1), 32'd1);
    @(posedge clk); #1 valid1 = 1'b0; rv1 = 1'b0;
    @(negedge clk);
    check("lat2_early", 32'(ov1), 32'd0);
    @(negedge clk);
    check("lat2_valid", 32'(ov1), 32'd1);

    // identity, 1000 maskings at full throughput
    @(posedge clk); #1;
    feed1(1000, 1, cyc);
    check("ident_throughput", 32'(cyc), 32'd1000);
    repeat (4) @(posedge clk); #1;
    check("ident_count", 32'(cnt1), 32'd9);    // 1001 mod 16
    check("ident_drained", 32'(exp1_q.size()), 32'd0);

    // back-pressure: 4 ops with out_ready low
    or1 = 1'b0;
    base = acc1;
    fork
      feed1(4, 0, cyc);
      begin
        repeat (4) @(posedge clk); #2;
        check("bp_ready_low", 32'(ready1), 32'd0);
        check("bp_two_accepts", 32'(acc1 - base), 32'd2);
        or1 = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check("bp_drained", 32'(exp1_q.size()), 32'd0);
    check("bp_count", 32'(cnt1), 32'd13);

    // exhaustive (a,b) with random back-pressure
    toggling = 1'b1;
    fork
      begin feed1(256, 2, cyc); toggling = 1'b0; end
      while (toggling) begin
        @(posedge clk); #1;
        if (toggling) or1 = 1'($urandom_range(0, 1));
      end
    join
    or1 = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("exh_drained", 32'(exp1_q.size()), 32'd0);
    check("exh_count", 32'(cnt1), 32'd13);   // 269 mod 16

    // reset between stage-1 and stage-2 edges
    set_ops1(4'h7, 4'h3);
    valid1 = 1'b1; rv1 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 valid1 = 1'b0; rv1 = 1'b0;
    #2 rst_n = 1'b0;
    exp0_q.delete(); exp1_q.delete();
    mcnt0 = '0; mcnt1 = '0;
    #1;
    check("midrst_ov1", 32'(ov1), 32'd0);
    check("midrst_c1", 32'(c1), 32'd0);
    check("midrst_cnt1", 32'(cnt1), 32'd0);
    check("midrst_cnt0", 32'(cnt0), 32'd0);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_flushed", 32'(ov1), 32'd0);
    end

    // counter wrap: 17 ops on a 4-bit counter
    @(posedge clk); #1;
    feed1(17, 0, cyc);
    repeat (4) @(posedge clk); #1;
    check("wrap_count", 32'(cnt1), 32'd1);

    // u0 random stream with random back-pressure
    toggling = 1'b1;
    fork
      begin feed0(20); toggling = 1'b0; end
      while (toggling) begin
        @(posedge clk); #1;
        if (toggling) or0 = 1'($urandom_range(0, 1));
      end
    join
    or0 = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("u0_stream_count", 32'(cnt0), 32'd20);
    check("u0_drained", 32'(exp0_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
